axis_seq_combiner: RTL and testbench

- Merges two AXI-Stream-style valid/ready inputs into one output stream in a fixed repeating pattern: FROM_PORT_ZERO beats from input 0, then FROM_PORT_ONE beats from input 1, then back to input 0.
- Sits between producers (e.g. separate data/side-channel sources) and a single consumer.
- Output is registered through a 2-entry skid buffer, so no combinational path runs from output_ready to the input readies.

---
 rtl/axis_seq_combiner.sv | 110 +++++++++++
 tb/tb_axis_seq_combiner.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_seq_combiner.sv
// Merges two valid/ready streams in a fixed repeating pattern.
// The pattern is FROM_PORT_ZERO beats from input 0, then FROM_PORT_ONE beats from input 1.
// A 2-entry buffer registers the output, so output_ready never reaches the input readies
// combinationally.
module axis_seq_combiner #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned FROM_PORT_ZERO = 1,
    parameter int unsigned FROM_PORT_ONE  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  input_0_valid,
    input  logic [DATA_WIDTH-1:0] input_0_data,
    output logic                  input_0_ready,
    input  logic                  input_1_valid,
    input  logic [DATA_WIDTH-1:0] input_1_data,
    output logic                  input_1_ready,
    output logic                  output_valid,
    output logic [DATA_WIDTH-1:0] output_data,
    input  logic                  output_ready
);

    localparam int unsigned NMax = (FROM_PORT_ZERO > FROM_PORT_ONE) ? FROM_PORT_ZERO
                                                                     : FROM_PORT_ONE;
    localparam int unsigned CntW = $clog2(NMax) + 1;
    // A port with a zero count is never selected, so start on port 1 if port 0 is empty.
    localparam logic SelInit = (FROM_PORT_ZERO == 0);

    if (FROM_PORT_ZERO == 0 && FROM_PORT_ONE == 0) begin : g_bad_cfg
        $error("axis_seq_combiner: FROM_PORT_ZERO and FROM_PORT_ONE cannot both be 0");
    end

    logic                  sel_q, sel_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  in_ready_q, in_ready_d;
    logic [1:0]            count_q, count_d;
    logic                  wr_ptr_q, rd_ptr_q;
    logic [DATA_WIDTH-1:0] mem_q [2];

    logic                  sel_valid;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  wr_en, rd_en, cnt_last;
    int unsigned           n_sel, n_other;

    // Input selection, round counting and buffer occupancy.
    always_comb begin
        sel_valid  = sel_q ? input_1_valid : input_0_valid;
        sel_data   = sel_q ? input_1_data : input_0_data;
        n_sel      = sel_q ? FROM_PORT_ONE : FROM_PORT_ZERO;
        n_other    = sel_q ? FROM_PORT_ZERO : FROM_PORT_ONE;
        wr_en      = in_ready_q && sel_valid;
        rd_en      = (count_q != 2'd0) && output_ready;
        cnt_last   = (32'(cnt_q) == n_sel - 32'd1);
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        if (wr_en) begin
            if (cnt_last) begin
                cnt_d = '0;
                // With an empty other port the same port simply repeats its round.
                if (n_other != 0) begin
                    sel_d = ~sel_q;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        count_d    = count_q + {1'b0, wr_en} - {1'b0, rd_en};
        // Ready is registered from the next occupancy, so it drops the cycle after filling.
        in_ready_d = (count_d != 2'd2);
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q      <= SelInit;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            count_q    <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
        end else begin
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
            count_q    <= count_d;
            if (wr_en) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (rd_en) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // Buffer storage; contents are qualified by count_q, so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= sel_data;
        end
    end

    // Output and per-port ready decode.
    always_comb begin
        output_valid  = (count_q != 2'd0);
        output_data   = mem_q[rd_ptr_q];
        input_0_ready = in_ready_q && !sel_q;
        input_1_ready = in_ready_q && sel_q;
    end

endmodule

// File: tb/tb_axis_seq_combiner.sv
// Scoreboard bench for axis_seq_combiner: three instances (16/7, 1/1, 0/3) run side by side.
// The expected port of each accepted beat comes from its position within the round.
module tb_axis_seq_combiner;

    logic        clk;
    logic        rst;
    logic        v0 [3];
    logic        v1 [3];
    logic        r0 [3];
    logic        r1 [3];
    logic        ov [3];
    logic        ordy [3];
    logic [15:0] d0 [3];
    logic [15:0] d1 [3];
    logic [15:0] od [3];

    int errors = 0;
    int checks = 0;
    int out_cnt [3];
    int pos [3];

    bit          a_stall = 0;
    bit          a_rand = 0;
    bit          drain = 0;
    bit          hs0 [3];
    bit          hs1 [3];
    bit          hold [3];
    logic [15:0] hold_data [3];
    logic [14:0] gen0 [3];
    logic [14:0] gen1 [3];

    logic [15:0] sb0[$];
    logic [15:0] sb1[$];
    logic [15:0] sb2[$];

    axis_seq_combiner #(.DATA_WIDTH(16), .FROM_PORT_ZERO(16), .FROM_PORT_ONE(7)) u_dut_a (
        .clk(clk), .rst(rst),
        .input_0_valid(v0[0]), .input_0_data(d0[0]), .input_0_ready(r0[0]),
        .input_1_valid(v1[0]), .input_1_data(d1[0]), .input_1_ready(r1[0]),
        .output_valid(ov[0]), .output_data(od[0]), .output_ready(ordy[0])
    );

    axis_seq_combiner #(.DATA_WIDTH(16), .FROM_PORT_ZERO(1), .FROM_PORT_ONE(1)) u_dut_b (
        .clk(clk), .rst(rst),
        .input_0_valid(v0[1]), .input_0_data(d0[1]), .input_0_ready(r0[1]),
        .input_1_valid(v1[1]), .input_1_data(d1[1]), .input_1_ready(r1[1]),
        .output_valid(ov[1]), .output_data(od[1]), .output_ready(ordy[1])
    );

    axis_seq_combiner #(.DATA_WIDTH(16), .FROM_PORT_ZERO(0), .FROM_PORT_ONE(3)) u_dut_c (
        .clk(clk), .rst(rst),
        .input_0_valid(v0[2]), .input_0_data(d0[2]), .input_0_ready(r0[2]),
        .input_1_valid(v1[2]), .input_1_data(d1[2]), .input_1_ready(r1[2]),
        .output_valid(ov[2]), .output_data(od[2]), .output_ready(ordy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int n0_of(int g);
        case (g)
            0: return 16;
            1: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int n1_of(int g);
        case (g)
            0: return 7;
            1: return 1;
            default: return 3;
        endcase
    endfunction

    // Port expected for the next accepted beat: first n0 slots of a round are port 0.
    function automatic int exp_port(int g);
        return ((pos[g] % (n0_of(g) + n1_of(g))) < n0_of(g)) ? 0 : 1;
    endfunction

    function automatic void sb_push(int g, logic [15:0] v);
        case (g)
            0: sb0.push_back(v);
            1: sb1.push_back(v);
            default: sb2.push_back(v);
        endcase
    endfunction

    function automatic logic [15:0] sb_pop(int g);
        case (g)
            0: return sb0.pop_front();
            1: return sb1.pop_front();
            default: return sb2.pop_front();
        endcase
    endfunction

    function automatic int sb_size(int g);
        case (g)
            0: return sb0.size();
            1: return sb1.size();
            default: return sb2.size();
        endcase
    endfunction

    function automatic void sb_flush(int g);
        case (g)
            0: sb0.delete();
            1: sb1.delete();
            default: sb2.delete();
        endcase
    endfunction

    // Stimulus: counting generators tagged with the port in bit 15; pushes expectations.
    initial begin : driver
        int cyc;
        cyc = 0;
        for (int g = 0; g < 3; g++) begin
            v0[g] = 1'b0; v1[g] = 1'b0; ordy[g] = 1'b1;
            gen0[g] = '0; gen1[g] = '0;
            d0[g] = 16'h0000; d1[g] = 16'h8000;
            pos[g] = 0; out_cnt[g] = 0;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                hs0[g] = 1'b0;
                hs1[g] = 1'b0;
                if (!rst) begin
                    sb_flush(g);
                    pos[g] = 0;
                end else begin
                    checks++;
                    if ((r0[g] && exp_port(g) != 0) || (r1[g] && exp_port(g) != 1)) begin
                        errors++;
                        $display("FAIL ready inst=%0d got r0=%b r1=%b expected port=%0d",
                                 g, r0[g], r1[g], exp_port(g));
                    end
                    hs0[g] = v0[g] && r0[g];
                    hs1[g] = v1[g] && r1[g];
                    if (hs0[g]) sb_push(g, d0[g]);
                    if (hs1[g]) sb_push(g, d1[g]);
                    if (hs0[g] || hs1[g]) pos[g]++;
                end
            end
            @(posedge clk);
            #1;
            cyc++;
            for (int g = 0; g < 3; g++) begin
                if (hs0[g]) gen0[g] = gen0[g] + 15'd1;
                if (hs1[g]) gen1[g] = gen1[g] + 15'd1;
                d0[g] = {1'b0, gen0[g]};
                d1[g] = {1'b1, gen1[g]};
                if (drain) begin
                    v0[g] = 1'b0; v1[g] = 1'b0; ordy[g] = 1'b1;
                end else if (g == 0) begin
                    if (a_rand) begin
                        if (!v0[g] || hs0[g]) v0[g] = ($urandom_range(3) != 0);
                        if (!v1[g] || hs1[g]) v1[g] = ($urandom_range(3) != 0);
                        ordy[g] = ($urandom_range(1) != 0);
                    end else begin
                        v0[g] = 1'b1; v1[g] = 1'b1; ordy[g] = !a_stall;
                    end
                end else if (g == 1) begin
                    v0[g] = 1'b1; v1[g] = (cyc % 3 == 0); ordy[g] = 1'b1;
                end else begin
                    v0[g] = 1'b1; v1[g] = 1'b1; ordy[g] = 1'b1;
                end
            end
        end
    end

    // Monitor: pops on every output handshake, checks hold stability and beats in flight.
    initial begin : monitor
        logic [15:0] exp;
        for (int g = 0; g < 3; g++) hold[g] = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            for (int g = 0; g < 3; g++) begin
                if (!rst) begin
                    hold[g] = 1'b0;
                end else begin
                    if (hold[g]) begin
                        checks++;
                        if (ov[g] !== 1'b1 || od[g] !== hold_data[g]) begin
                            errors++;
                            $display("FAIL hold inst=%0d got v=%b d=%h expected v=1 d=%h",
                                     g, ov[g], od[g], hold_data[g]);
                        end
                    end
                    if (ov[g] && ordy[g]) begin
                        checks++;
                        out_cnt[g]++;
                        if (sb_size(g) == 0) begin
                            errors++;
                            $display("FAIL data inst=%0d got=%h expected=<none>", g, od[g]);
                        end else begin
                            exp = sb_pop(g);
                            if (od[g] !== exp) begin
                                errors++;
                                $display("FAIL data inst=%0d got=%h expected=%h", g, od[g], exp);
                            end
                        end
                    end
                    checks++;
                    if (sb_size(g) > 2) begin
                        errors++;
                        $display("FAIL inflight inst=%0d got=%0d expected<=2", g, sb_size(g));
                    end
                    hold[g] = ov[g] && !ordy[g];
                    hold_data[g] = od[g];
                end
            end
        end
    end

    // Sequencer: reset, streaming, stall, mid-run reset, random traffic, drain.
    initial begin : sequencer
        int base;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (ov[g] !== 1'b0 || r0[g] !== 1'b0 || r1[g] !== 1'b0) begin
                errors++;
                $display("FAIL reset inst=%0d got v=%b r0=%b r1=%b expected 0 0 0",
                         g, ov[g], r0[g], r1[g]);
            end
        end
        @(posedge clk);
        #3 rst = 1'b1;

        for (int i = 0; i < 20 && out_cnt[0] == 0; i++) @(posedge clk);
        checks++;
        if (out_cnt[0] == 0) begin
            errors++;
            $display("FAIL first_out inst=0 got=none expected=beat within 20 cycles");
        end else begin
            base = out_cnt[0];
            repeat (45) @(posedge clk);
            checks++;
            if (out_cnt[0] - base != 45) begin
                errors++;
                $display("FAIL throughput inst=0 got=%0d expected=45", out_cnt[0] - base);
            end
        end

        @(posedge clk);
        a_stall = 1'b1;
        repeat (5) @(posedge clk);
        checks++;
        if (sb_size(0) != 2) begin
            errors++;
            $display("FAIL stall_fill inst=0 got=%0d expected=2", sb_size(0));
        end

        #3 rst = 1'b0;
        #1;
        checks++;
        if (ov[0] !== 1'b0 || r0[0] !== 1'b0 || r1[0] !== 1'b0) begin
            errors++;
            $display("FAIL async_reset inst=0 got v=%b r0=%b r1=%b expected 0 0 0",
                     ov[0], r0[0], r1[0]);
        end
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        a_stall = 1'b0;

        repeat (60) @(posedge clk);
        a_rand = 1'b1;
        repeat (2000) @(posedge clk);
        a_rand = 1'b0;
        drain = 1'b1;
        repeat (30) @(posedge clk);
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (sb_size(g) != 0) begin
                errors++;
                $display("FAIL drain inst=%0d got=%0d left expected=0", g, sb_size(g));
            end
            checks++;
            if (out_cnt[g] < 100) begin
                errors++;
                $display("FAIL progress inst=%0d got=%0d beats expected>=100", g, out_cnt[g]);
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
